neurram_reg_spi_engine: RTL and testbench

Serial shift engine that drives the NeuRRAM core register chains during an SPI load or readback. It produces the `state_spi_clk` / `state_spi_idle` pair consumed by the register control FSM, which gates them onto the chip `spi_clk` lines. It serializes host words onto `sdo` and deserializes the chain tail `sdi` into host words. Word traffic uses valid/ready handshakes on both sides; backpressure stalls the serial clock rather than dropping bits.

---
 rtl/neurram_reg_spi_engine.sv | 128 ++++++++++++
 tb/tb_neurram_reg_spi_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/neurram_reg_spi_engine.sv
// neurram_reg_spi_engine: serial shift engine for the NeuRRAM register chains
// Ports: clk/rst (async, active-high); start/num_bits/clk_div launch a transfer;
// tx_data/tx_valid/tx_ready feed words to sdo LSB first; sdi is deserialized into
// rx_data/rx_valid/rx_ready; state_spi_clk/state_spi_idle drive the register FSM;
// done pulses once at the end of a transfer.
// Build option: define NEURRAM_SPI_RX_EN to include the rx deserializer.
module neurram_reg_spi_engine #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_bits,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              sdo,
  input  logic              sdi,
  output logic              state_spi_clk,
  output logic              state_spi_idle,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, TAIL, FINISH} state_t;
  localparam logic [CNT_W-1:0] WW = CNT_W'(WORD_W);
  state_t state;
  logic [CNT_W-1:0] nb, bcnt, bnext;
  logic [DIV_W-1:0] cdiv, dcnt;
  logic [WORD_W-1:0] txsh;
  logic phase_end, stall, pend, hold_free;
  assign phase_end = dcnt == cdiv;
  assign bnext = bcnt + 1'b1;
  assign state_spi_clk = state == HIGH;
  assign state_spi_idle = state == IDLE;
  assign tx_ready = state == FETCH;
  assign sdo = (state == LOW || state == HIGH) && txsh[0];
`ifdef NEURRAM_SPI_RX_EN
  localparam int RW = $clog2(WORD_W);
  logic [RW-1:0] rcnt;
  logic [WORD_W-1:0] rxsh;
  logic word_done, cap, fin, push;
  assign word_done = rcnt == RW'(WORD_W - 1);
  // a full word cannot land while the holding register is still owned by the host
  assign stall = word_done && rx_valid && !rx_ready;
  assign pend = rcnt != '0;
  assign hold_free = !rx_valid || rx_ready;
  assign cap = state == LOW && phase_end && !stall;
  assign fin = (state == TAIL && phase_end) || (state == FINISH && !done);
  assign push = (cap && word_done) || (fin && pend && hold_free);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rcnt <= '0;
      rxsh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (cap) begin
        rxsh <= {sdi, rxsh[WORD_W-1:1]};
        rcnt <= rcnt + 1'b1;
      end else if (state == IDLE) rcnt <= '0;
      // partial words sit in the top bits; shifting down zero-pads the upper bits
      if (push) begin
        rx_data <= cap ? {sdi, rxsh[WORD_W-1:1]} : rxsh >> (WORD_W - int'(rcnt));
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
`else
  logic unused_rx;
  assign unused_rx = sdi ^ rx_ready;
  assign stall = 1'b0;
  assign pend = 1'b0;
  assign hold_free = 1'b1;
  assign rx_data = '0;
  assign rx_valid = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      nb <= '0;
      cdiv <= '0;
      bcnt <= '0;
      dcnt <= '0;
      txsh <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && num_bits != '0) begin
          nb <= num_bits;
          cdiv <= clk_div;
          bcnt <= '0;
          dcnt <= '0;
          state <= FETCH;
        end
        FETCH: if (tx_valid) begin
          txsh <= tx_data;
          dcnt <= '0;
          state <= LOW;
        end
        LOW: if (!phase_end) dcnt <= dcnt + 1'b1;
          else if (!stall) begin
            dcnt <= '0;
            state <= HIGH;
          end
        HIGH: if (!phase_end) dcnt <= dcnt + 1'b1;
          else begin
            dcnt <= '0;
            bcnt <= bnext;
            txsh <= txsh >> 1;
            state <= bnext == nb ? TAIL : (bnext % WW) == '0 ? FETCH : LOW;
          end
        TAIL: if (!phase_end) dcnt <= dcnt + 1'b1;
          else begin
            dcnt <= '0;
            done <= !pend || hold_free;
            state <= FINISH;
          end
        FINISH: if (done) state <= IDLE;
          else done <= !pend || hold_free;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_neurram_reg_spi_engine.sv
// tb_neurram_reg_spi_engine: directed self-checking bench for neurram_reg_spi_engine
module tb_neurram_reg_spi_engine;
`ifdef NEURRAM_SPI_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0, sdi = 1'b0;
  logic [15:0] num_bits = '0;
  logic [7:0] clk_div = '0;
  logic [31:0] tx_data = '0, rx_data;
  logic tx_ready, rx_valid, sdo, state_spi_clk, state_spi_idle, done;
  int errors = 0, checks = 0;
  int pulses, c_done, hs, rxv_seen, bad_high, bad_low, maxlow, pulses_at_rel;
  logic idle_after, idle_c1, spi_at_rel, fin_rxv;
  logic [31:0] fin_rx;
  logic [63:0] bits, pat;
  logic [31:0] rxw [4];
  logic [31:0] txw [4];

  neurram_reg_spi_engine dut (
    .clk(clk), .rst(rst), .start(start), .num_bits(num_bits), .clk_div(clk_div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sdo(sdo), .sdi(sdi), .state_spi_clk(state_spi_clk),
    .state_spi_idle(state_spi_idle), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // runs one transfer; sf/sg = fetch index and length of a tx_valid gap,
  // rel = cycle at which rx_ready is raised (0: high throughout)
  task automatic xfer(input logic [15:0] n, input logic [7:0] d, input int sf, input int sg, input int rel);
    int c, fidx, gap, hr, lr;
    logic prev;
    c = 0; fidx = 0; gap = sg; hr = 0; lr = 0; prev = 1'b0;
    pulses = 0; bits = '0; c_done = -1; hs = 0; rxv_seen = 0; bad_high = 0; bad_low = 0;
    maxlow = 0; idle_after = 1'b0; idle_c1 = 1'b1; spi_at_rel = 1'bx; pulses_at_rel = -1;
    fin_rx = 'x; fin_rxv = 1'bx;
    for (int i = 0; i < 4; i++) rxw[i] = '0;
    rx_ready = (rel == 0);
    @(negedge clk);
    num_bits = n; clk_div = d; start = 1'b1; tx_valid = 1'b1; sdi = pat[0];
    while (c < 2000 && !(c_done >= 0 && c > c_done)) begin
      @(negedge clk);
      c++;
      start = (c == 20);
      if (c == 20) num_bits = 16'd3;
      if (c == 1) idle_c1 = state_spi_idle;
      if (rel > 0 && c == rel) begin
        spi_at_rel = state_spi_clk;
        pulses_at_rel = pulses;
        rx_ready = 1'b1;
      end
      if (state_spi_clk && !prev) begin
        if (pulses < 64) bits[pulses] = sdo;
        if (pulses > 0) begin
          if (lr != int'(d) + 1) bad_low++;
          if (lr > maxlow) maxlow = lr;
        end
        pulses++;
        hr = 0;
      end
      if (!state_spi_clk && prev) begin
        if (hr != int'(d) + 1) bad_high++;
        lr = 0;
      end
      if (state_spi_clk) hr++; else lr++;
      prev = state_spi_clk;
      if (rx_valid) rxv_seen++;
      if (rx_valid && rx_ready) begin
        if (hs < 4) rxw[hs] = rx_data;
        hs++;
      end
      if (done && c_done < 0) begin
        c_done = c;
        fin_rx = rx_data;
        fin_rxv = rx_valid;
      end
      if (c_done >= 0 && c == c_done + 1) idle_after = state_spi_idle;
      sdi = pulses < 64 ? pat[pulses] : 1'b0;
      if (tx_ready) begin
        if (fidx == sf && gap > 0) begin
          tx_valid = 1'b0;
          gap--;
        end else begin
          tx_valid = 1'b1;
          tx_data = fidx < 4 ? txw[fidx] : 32'h0;
          fidx++;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_spi_clk"}, state_spi_clk, 0);
    chk({tag, "_idle"}, state_spi_idle, 1);
    chk({tag, "_sdo"}, sdo, 0);
    chk({tag, "_tx_ready"}, tx_ready, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) txw[i] = '0;
    pat = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("post_reset");

    num_bits = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_start_idle", state_spi_idle, 1);
    chk("zero_start_tx_ready", tx_ready, 0);
    repeat (3) @(negedge clk);
    chk("zero_start_idle_later", state_spi_idle, 1);

    txw[0] = 32'hA; pat = 64'h5;
    xfer(16'd4, 8'd0, -1, 0, 0);
    chk("basic_done_cycle", c_done, 11);
    chk("basic_idle_c1", idle_c1, 0);
    chk("basic_idle_after", idle_after, 1);
    chk("basic_pulses", pulses, 4);
    chk("basic_sdo", bits[3:0], 4'hA);
    chk("basic_high_len", bad_high, 0);
    chk("basic_low_len", bad_low, 0);
    chk("basic_rxv_cycles", rxv_seen, RX ? 1 : 0);
    chk("basic_rx_hs", hs, RX ? 1 : 0);
`ifdef NEURRAM_SPI_RX_EN
    chk("basic_rx_word", rxw[0], 32'h5);
`endif

    txw[0] = 32'h0F0F0F0F; txw[1] = 32'h000000AA; pat = '1;
    xfer(16'd40, 8'd0, -1, 0, 0);
    chk("partial_done_cycle", c_done, 84);
    chk("partial_pulses", pulses, 40);
    chk("partial_sdo", bits[39:0], 40'hAA_0F0F0F0F);
    chk("partial_rx_hs", hs, RX ? 2 : 0);
    chk("partial_fin_rx", fin_rx, RX ? 32'hFF : 32'h0);
    chk("partial_fin_rxv", fin_rxv, RX);
`ifdef NEURRAM_SPI_RX_EN
    chk("partial_rx_word0", rxw[0], 32'hFFFFFFFF);
    chk("partial_rx_word1", rxw[1], 32'h000000FF);
`endif

    txw[0] = 32'h12345678; txw[1] = 32'hFFFFFFF9; pat = '0;
    xfer(16'd36, 8'd3, 1, 10, 0);
    chk("div_done_cycle", c_done, 305);
    chk("div_sdo", bits[35:0], 36'h9_1234_5678);
    chk("div_high_len", bad_high, 0);
    chk("div_low_irregular", bad_low, 1);
    chk("div_low_max", maxlow, 15);

    txw[0] = 32'hCAFEF00D; txw[1] = 32'h01234567; pat = 64'hDEADBEEF_0F1E2D3C;
    xfer(16'd64, 8'd0, -1, 0, 150);
    chk("bp_sdo", bits, 64'h01234567_CAFEF00D);
`ifdef NEURRAM_SPI_RX_EN
    chk("bp_done_cycle", c_done, 153);
    chk("bp_stall_spi_clk", spi_at_rel, 0);
    chk("bp_stall_pulses", pulses_at_rel, 63);
    chk("bp_rx_hs", hs, 2);
    chk("bp_rx_word0", rxw[0], 32'h0F1E2D3C);
    chk("bp_rx_word1", rxw[1], 32'hDEADBEEF);
`else
    chk("bp_done_cycle", c_done, 132);
    chk("bp_pulses", pulses, 64);
    chk("bp_rx_hs", hs, 0);
`endif

    txw[0] = 32'hFF; pat = '1;
    @(negedge clk);
    num_bits = 16'd8; clk_div = 8'd2; start = 1'b1; tx_valid = 1'b1; tx_data = 32'hFF; sdi = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !state_spi_clk; i++) @(negedge clk);
    chk("abort_high_reached", state_spi_clk, 1);
    #2 rst = 1'b1;
    #1 chk_reset("abort");
    @(negedge clk);
    rst = 1'b0;

    txw[0] = 32'hA; pat = 64'h5;
    xfer(16'd4, 8'd0, -1, 0, 0);
    chk("rerun_done_cycle", c_done, 11);
    chk("rerun_sdo", bits[3:0], 4'hA);
    chk("rerun_pulses", pulses, 4);
    chk("rerun_rxv_cycles", rxv_seen, RX ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
